// File: rtl/mcore_pkg.sv
// Shared types for the mcore memory arbiter: requester limit and FSM encoding.
// No logic, no latency; types only.
package mcore_pkg;

    localparam int MCORE_ARB_MAX_REQ = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } mcore_arb_state_t;

endpackage

// File: rtl/mcore_id_fifo.sv
// In-order owner-ID FIFO; push/pop take effect at the clock edge, head is the registered oldest entry.
// Backpressure: pushes while full and pops while empty are ignored; callers gate with full/empty.
module mcore_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/mcore_mem_arbiter.sv
// Round-robin arbiter of N requesters onto one memory port; zero-cycle request, grant and response paths.
// Backpressure: selection locks until mem_gnt; no new request is issued while MAX_OUTSTANDING are unanswered.
module mcore_mem_arbiter
    import mcore_pkg::*;
#(
    parameter int N_REQ           = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               aclk,
    input  logic                               aresetn,
    input  logic [N_REQ-1:0]                   s_req,
    input  logic [N_REQ*ADDR_WIDTH-1:0]        s_addr,
    input  logic [N_REQ-1:0]                   s_we,
    input  logic [N_REQ*DATA_WIDTH-1:0]        s_wdata,
    input  logic [N_REQ*DATA_WIDTH/8-1:0]      s_be,
    output logic [N_REQ-1:0]                   s_gnt,
    output logic [N_REQ-1:0]                   s_rsp_valid,
    output logic [DATA_WIDTH-1:0]              s_rsp_rdata,
    output logic                               s_rsp_error,
    output logic                               mem_req,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_we,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    output logic [DATA_WIDTH/8-1:0]            mem_be,
    input  logic                               mem_gnt,
    input  logic                               mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_rsp_rdata,
    input  logic                               mem_rsp_error,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               err_unexpected_rsp
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW   = DATA_WIDTH / 8;

    mcore_arb_state_t state_q, state_d;
    logic [IDXW-1:0]  sel_q;
    logic [IDXW-1:0]  rr_ptr_q;
    logic [IDXW-1:0]  rr_nxt;
    logic [IDXW-1:0]  pick;
    logic [IDXW-1:0]  off;
    logic [IDXW:0]    sum;
    logic [IDXW-1:0]  cur;
    logic [N_REQ-1:0] rot;
    logic [IDXW-1:0]  head;
    logic             issue;
    logic             granted;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             err_q;

    // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit wins.
    assign rot = N_REQ'({s_req, s_req} >> rr_ptr_q);

    always_comb begin
        off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDXW'(k);
            end
        end
    end

    assign sum  = {1'b0, rr_ptr_q} + {1'b0, off};
    assign pick = (sum >= (IDXW+1)'(N_REQ)) ? IDXW'(sum - (IDXW+1)'(N_REQ)) : sum[IDXW-1:0];

    assign cur     = (state_q == ARB_LOCKED) ? sel_q : pick;
    assign issue   = (state_q == ARB_LOCKED) || (!fifo_full && (|s_req));
    assign granted = issue && mem_gnt;
    assign rr_nxt  = (cur == IDXW'(N_REQ - 1)) ? '0 : cur + IDXW'(1);

    assign mem_req   = issue;
    assign mem_addr  = issue ? s_addr[int'(cur)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign mem_we    = issue ? s_we[cur] : 1'b0;
    assign mem_wdata = issue ? s_wdata[int'(cur)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign mem_be    = issue ? s_be[int'(cur)*BW +: BW] : '0;
    assign s_gnt     = granted ? (N_REQ'(1) << cur) : '0;

    assign pop                = mem_rsp_valid && !fifo_empty;
    assign s_rsp_valid        = pop ? (N_REQ'(1) << head) : '0;
    assign s_rsp_rdata        = mem_rsp_rdata;
    assign s_rsp_error        = mem_rsp_error;
    assign err_unexpected_rsp = err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (issue && !mem_gnt) state_d = ARB_LOCKED;
            ARB_LOCKED: if (mem_gnt)           state_d = ARB_IDLE;
            default:                           state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ARB_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ARB_IDLE && issue) begin
                sel_q <= pick;
            end
            if (granted) begin
                rr_ptr_q <= rr_nxt;
            end
            if (mem_rsp_valid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    mcore_id_fifo #(
        .WIDTH (IDXW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (aclk),
        .aresetn   (aresetn),
        .push      (granted),
        .push_data (cur),
        .pop       (pop),
        .head      (head),
        .count     (outstanding),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mcore_mem_arbiter.sv
// Randomized and directed bench for mcore_mem_arbiter against a transaction-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_mcore_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;

    logic              aclk;
    logic              aresetn;
    logic [N-1:0]      s_req;
    logic [N*AW-1:0]   s_addr;
    logic [N-1:0]      s_we;
    logic [N*DW-1:0]   s_wdata;
    logic [N*BW-1:0]   s_be;
    logic [N-1:0]      s_gnt;
    logic [N-1:0]      s_rsp_valid;
    logic [DW-1:0]     s_rsp_rdata;
    logic              s_rsp_error;
    logic              mem_req;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [BW-1:0]     mem_be;
    logic              mem_gnt;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rsp_rdata;
    logic              mem_rsp_error;
    logic [CW-1:0]     outstanding;
    logic              err_unexpected_rsp;

    mcore_mem_arbiter #(
        .N_REQ           (N),
        .DATA_WIDTH      (DW),
        .ADDR_WIDTH      (AW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .s_req              (s_req),
        .s_addr             (s_addr),
        .s_we               (s_we),
        .s_wdata            (s_wdata),
        .s_be               (s_be),
        .s_gnt              (s_gnt),
        .s_rsp_valid        (s_rsp_valid),
        .s_rsp_rdata        (s_rsp_rdata),
        .s_rsp_error        (s_rsp_error),
        .mem_req            (mem_req),
        .mem_addr           (mem_addr),
        .mem_we             (mem_we),
        .mem_wdata          (mem_wdata),
        .mem_be             (mem_be),
        .mem_gnt            (mem_gnt),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rsp_rdata      (mem_rsp_rdata),
        .mem_rsp_error      (mem_rsp_error),
        .outstanding        (outstanding),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester agents: a pending transaction is held stable until granted.
    bit            r_act   [N];
    logic [AW-1:0] r_addr  [N];
    logic          r_we    [N];
    logic [DW-1:0] r_wdata [N];
    logic [BW-1:0] r_be    [N];

    // Reference model: owners in grant order, last granted requester, locked owner.
    int m_q[$];
    int m_last;
    int m_lock;
    bit m_err;
    int m_mem_pend;
    int gnt_log[$];
    int rsp_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic new_req(input int i);
        r_act[i]   = 1'b1;
        r_addr[i]  = $urandom;
        r_we[i]    = 1'($urandom_range(0, 1));
        r_wdata[i] = $urandom;
        r_be[i]    = BW'($urandom);
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < N; i++) begin
            s_req[i]               = r_act[i];
            s_we[i]                = r_we[i];
            s_addr[i*AW +: AW]     = r_addr[i];
            s_wdata[i*DW +: DW]    = r_wdata[i];
            s_be[i*BW +: BW]       = r_be[i];
        end
    endtask

    function automatic int exp_owner();
        if (m_lock >= 0) return m_lock;
        if (m_q.size() >= MO) return -1;
        for (int k = 1; k <= N; k++) begin
            if (r_act[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_last     = N - 1;
        m_lock     = -1;
        m_err      = 1'b0;
        m_mem_pend = 0;
    endtask

    // One clock: apply inputs, compare on the falling edge, advance the model, return after the rising edge.
    task automatic cycle();
        int own;
        int rsp_to;
        bit g;
        pack_inputs();
        @(negedge aclk);
        own    = exp_owner();
        g      = (own >= 0) && mem_gnt;
        rsp_to = (mem_rsp_valid && m_q.size() > 0) ? m_q[0] : -1;
        check_eq("mem_req", 64'(mem_req), 64'(own >= 0));
        if (own >= 0) begin
            check_eq("mem_addr", 64'(mem_addr), 64'(r_addr[own]));
            check_eq("mem_we", 64'(mem_we), 64'(r_we[own]));
            check_eq("mem_wdata", 64'(mem_wdata), 64'(r_wdata[own]));
            check_eq("mem_be", 64'(mem_be), 64'(r_be[own]));
        end else begin
            check_eq("mem_addr_idle", 64'(mem_addr), 64'd0);
        end
        check_eq("s_gnt", 64'(s_gnt), g ? (64'd1 << own) : 64'd0);
        check_eq("s_rsp_valid", 64'(s_rsp_valid), (rsp_to >= 0) ? (64'd1 << rsp_to) : 64'd0);
        if (mem_rsp_valid) begin
            check_eq("s_rsp_rdata", 64'(s_rsp_rdata), 64'(mem_rsp_rdata));
            check_eq("s_rsp_error", 64'(s_rsp_error), 64'(mem_rsp_error));
        end
        check_eq("outstanding", 64'(outstanding), 64'(m_q.size()));
        check_eq("err_unexpected_rsp", 64'(err_unexpected_rsp), 64'(m_err));
        // A response pops against the pre-edge FIFO contents, before any same-cycle push.
        if (mem_rsp_valid) begin
            if (m_q.size() > 0) begin
                rsp_log.push_back(m_q.pop_front());
            end else begin
                m_err = 1'b1;
            end
            if (m_mem_pend > 0) m_mem_pend--;
        end
        if (own >= 0) begin
            if (mem_gnt) begin
                m_q.push_back(own);
                m_last = own;
                m_lock = -1;
                gnt_log.push_back(own);
                m_mem_pend++;
                r_act[own] = 1'b0;
            end else begin
                m_lock = own;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        for (int i = 0; i < N; i++) r_act[i] = 1'b0;
        mem_gnt       = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        mem_rsp_error = 1'b0;
        pack_inputs();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        model_clear();
    endtask

    task automatic grant_one(input int i);
        new_req(i);
        mem_gnt = 1'b1;
        cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < N; i++) r_act[i] = 1'b0;
        mem_gnt = 1'b0;
        for (int c = 0; c < 40 && (m_mem_pend > 0 || m_lock >= 0); c++) begin
            mem_gnt       = (m_lock >= 0);
            mem_rsp_valid = (m_mem_pend > 0);
            mem_rsp_rdata = $urandom;
            mem_rsp_error = 1'($urandom_range(0, 1));
            cycle();
        end
        check_eq("drain_done", 64'(m_q.size()), 64'd0);
        mem_gnt       = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        s_req = '0; s_addr = '0; s_we = '0; s_wdata = '0; s_be = '0;
        for (int i = 0; i < N; i++) begin
            r_act[i] = 1'b0; r_addr[i] = '0; r_we[i] = 1'b0; r_wdata[i] = '0; r_be[i] = '0;
        end
        model_clear();
        do_reset();
        do_reset();
        cycle();

        // Single read, granted the same cycle, answered two cycles later.
        r_act[0] = 1'b1; r_addr[0] = 32'h100; r_we[0] = 1'b0; r_wdata[0] = '0; r_be[0] = '1;
        mem_gnt = 1'b1;
        gnt_log.delete(); rsp_log.delete();
        cycle();
        mem_gnt = 1'b0;
        cycle();
        mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hDEADBEEF;
        cycle();
        mem_rsp_valid = 1'b0;
        cycle();
        check_eq("single_gnt_owner", 64'(gnt_log.size() == 1 && gnt_log[0] == 0), 64'd1);
        check_eq("single_rsp_owner", 64'(rsp_log.size() == 1 && rsp_log[0] == 0), 64'd1);

        // Fairness: requesters 0 and 1 always requesting.
        gnt_log.delete();
        for (int c = 0; c < 40 && gnt_log.size() < 8; c++) begin
            if (!r_act[0]) new_req(0);
            if (!r_act[1]) new_req(1);
            mem_gnt       = 1'b1;
            mem_rsp_valid = (m_mem_pend > 0);
            mem_rsp_rdata = $urandom;
            cycle();
        end
        check_eq("fair_count", 64'(gnt_log.size()), 64'd8);
        for (int k = 1; k < gnt_log.size(); k++) begin
            check_eq("fair_alternate", 64'(gnt_log[k] != gnt_log[k-1]), 64'd1);
        end
        drain();

        // Lock under backpressure: requester 1 arrives while 0 waits for mem_gnt.
        gnt_log.delete();
        new_req(0);
        mem_gnt = 1'b0;
        cycle();
        new_req(1);
        cycle();
        cycle();
        mem_gnt = 1'b1;
        cycle();
        cycle();
        check_eq("lock_order", 64'(gnt_log.size() == 2 && gnt_log[0] == 0 && gnt_log[1] == 1), 64'd1);
        drain();

        // FIFO full: five back-to-back requests, no responses.
        gnt_log.delete();
        mem_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (!r_act[0]) new_req(0);
            cycle();
        end
        check_eq("full_grants", 64'(gnt_log.size()), 64'(MO));
        mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom;
        cycle();
        check_eq("full_pop_no_grant", 64'(gnt_log.size()), 64'(MO));
        mem_rsp_valid = 1'b0;
        cycle();
        check_eq("full_fifth_grant", 64'(gnt_log.size()), 64'(MO + 1));
        drain();

        // In-order routing: grants 0,1,1,0 then four responses.
        rsp_log.delete();
        grant_one(0); grant_one(1); grant_one(1); grant_one(0);
        mem_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'hA + 32'(k);
            cycle();
        end
        mem_rsp_valid = 1'b0;
        check_eq("route_order", 64'(rsp_log.size() == 4 && rsp_log[0] == 0 && rsp_log[1] == 1
                                    && rsp_log[2] == 1 && rsp_log[3] == 0), 64'd1);

        // Unexpected response is sticky.
        mem_rsp_valid = 1'b1;
        cycle();
        mem_rsp_valid = 1'b0;
        repeat (3) cycle();
        check_eq("err_sticky", 64'(err_unexpected_rsp), 64'd1);

        // Reset mid-operation with two outstanding and one locked request.
        do_reset();
        grant_one(0); grant_one(1);
        new_req(2);
        mem_gnt = 1'b0;
        cycle();
        check_eq("pre_reset_outstanding", 64'(outstanding), 64'd2);
        do_reset();
        cycle();
        check_eq("post_reset_outstanding", 64'(outstanding), 64'd0);
        check_eq("post_reset_mem_req", 64'(mem_req), 64'd0);
        mem_rsp_valid = 1'b1;
        cycle();
        mem_rsp_valid = 1'b0;
        cycle();
        check_eq("stale_rsp_err", 64'(err_unexpected_rsp), 64'd1);
        do_reset();

        // Randomized traffic in three phases: fill, heavy backpressure, balanced.
        for (int c = 0; c < 1500; c++) begin
            int ph;
            ph = c / 500;
            for (int i = 0; i < N; i++) begin
                if (!r_act[i] && $urandom_range(0, 1) == 1) new_req(i);
            end
            case (ph)
                0:       mem_gnt = ($urandom_range(0, 7) != 0);
                1:       mem_gnt = ($urandom_range(0, 3) == 0);
                default: mem_gnt = ($urandom_range(0, 1) == 1);
            endcase
            mem_rsp_valid = (m_mem_pend > 0) && ($urandom_range(0, 2) == 0 || ph == 2);
            mem_rsp_rdata = $urandom;
            mem_rsp_error = 1'($urandom_range(0, 1));
            cycle();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
